// File: rtl/key_capture_pkg.sv
// Shared types and defaults for the key capture block and its bench.
package key_capture_pkg;

  localparam int KEY_W_DEF    = 8;
  localparam int DEBOUNCE_DEF = 16;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_HOLD         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

endpackage : key_capture_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared to 0 on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First flop may go metastable; second flop gives a settled copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff

// File: rtl/key_onehot_capture.sv
// Debounces a bank of key lines and hands a single one-hot key pattern to a
// downstream encoder with a valid/ack handshake. Multi-key chords are rejected.
module key_onehot_capture
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int KEY_W           = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             data_ack,
  output logic [KEY_W-1:0] data_out,
  output logic             data_valid,
  output logic             multi_key
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [KEY_W-1:0] KEY_ONE  = KEY_W'(1);

  logic [KEY_W-1:0] w_key_s;
  logic             w_cand_onehot;
  logic             w_cnt_last;

  state_t           r_state;
  logic [KEY_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_multi_key;

  sync_2ff #(
    .WIDTH (KEY_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (w_key_s)
  );

  // A candidate is one-hot when it is non-zero and has a single bit set
  assign w_cand_onehot = (r_cand != '0) && ((r_cand & (r_cand - KEY_ONE)) == '0);
  assign w_cnt_last    = (r_cnt == CNT_LAST);

  // Capture FSM: every terminal count leaves its state, so cnt never wraps.
  // cnt is cleared on each entry to WAIT_RELEASE so a full release window is
  // always required before the next press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_multi_key  <= 1'b0;
    end else begin
      r_multi_key <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_key_s != '0) begin
            r_cand  <= w_key_s;
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_key_s == r_cand) begin
            if (w_cnt_last) begin
              r_cnt <= '0;
              if (w_cand_onehot) begin
                r_data_out   <= r_cand;
                r_data_valid <= 1'b1;
                r_state      <= ST_HOLD;
              end else begin
                r_multi_key <= 1'b1;
                r_state     <= ST_WAIT_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (w_key_s == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cand <= w_key_s;
            r_cnt  <= '0;
          end
        end
        ST_HOLD: begin
          if (data_ack) begin
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
            r_cnt        <= '0;
            r_state      <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_key_s != '0) begin
            r_cnt <= '0;
          end else if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign multi_key  = r_multi_key;

endmodule : key_onehot_capture

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with a run-length reference model.
module tb_key_onehot_capture;

  localparam int DC = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_in;
  logic       data_ack;
  logic [7:0] data_out;
  logic       data_valid;
  logic       multi_key;

  int compared   = 0;
  int mismatched = 0;

  key_onehot_capture #(
    .DEBOUNCE_CYCLES (DC),
    .KEY_W           (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .multi_key  (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = armed, 1 = holding a key, 2 = awaiting release.
  // A press is taken once DC+1 consecutive identical non-zero synchronized
  // samples are seen while armed; release needs DC consecutive zero samples.
  typedef struct packed {
    logic [7:0] s1;
    logic [7:0] s2;
    int         phase;
    int         run;
    logic [7:0] last;
    int         zrun;
    logic [7:0] out;
    logic       valid;
    logic       multi;
  } mstate_t;

  localparam mstate_t M_RESET = '{s1: 8'h00, s2: 8'h00, phase: 0, run: 0, last: 8'h00,
                                  zrun: 0, out: 8'h00, valid: 1'b0, multi: 1'b0};

  mstate_t m;

  function automatic mstate_t mstep(mstate_t cur, logic [7:0] kin, logic ack);
    mstate_t    n;
    logic [7:0] ks;
    n       = cur;
    ks      = cur.s2;
    n.s2    = cur.s1;
    n.s1    = kin;
    n.multi = 1'b0;
    if (cur.phase == 0) begin
      if (ks == 8'h00)                         n.run = 0;
      else if (ks == cur.last && cur.run > 0)  n.run = cur.run + 1;
      else                                     n.run = 1;
      n.last = ks;
      if (n.run == DC + 1) begin
        if ($countones(ks) == 1) begin
          n.out   = ks;
          n.valid = 1'b1;
          n.phase = 1;
        end else begin
          n.multi = 1'b1;
          n.phase = 2;
          n.zrun  = 0;
        end
        n.run = 0;
      end
    end else if (cur.phase == 1) begin
      if (ack) begin
        n.out   = 8'h00;
        n.valid = 1'b0;
        n.phase = 2;
        n.zrun  = 0;
      end
    end else begin
      n.zrun = (ks == 8'h00) ? cur.zrun + 1 : 0;
      if (n.zrun == DC) begin
        n.phase = 0;
        n.run   = 0;
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the design
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else        m <= mstep(m, key_in, data_ack);
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    compared++;
    if ({data_out, data_valid, multi_key} !== {m.out, m.valid, m.multi}) begin
      mismatched++;
      $display("FAIL model_cmp t=%0t: got out=%h valid=%b multi=%b, expected out=%h valid=%b multi=%b",
               $time, data_out, data_valid, multi_key, m.out, m.valid, m.multi);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply a key and verify it is accepted exactly 2+DC edges after first sample
  task automatic accept(input logic [7:0] k, input string name);
    key_in = k;
    tick(2 + DC);
    check({name, "_not_yet"}, {31'd0, data_valid}, 32'd0);
    tick(1);
    check({name, "_valid"}, {31'd0, data_valid}, 32'd1);
    check({name, "_data"}, {24'd0, data_out}, {24'd0, k});
  endtask

  task automatic do_ack(input string name);
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
    check({name, "_ack_valid"}, {31'd0, data_valid}, 32'd0);
    check({name, "_ack_data"}, {24'd0, data_out}, 32'd0);
  endtask

  initial begin
    int seen_valid;
    int multi_cnt;
    int held_cnt;

    rst_n    = 1'b0;
    key_in   = 8'h00;
    data_ack = 1'b0;
    tick(3);
    check("reset_data",  {24'd0, data_out}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_multi", {31'd0, multi_key}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    $display("txn reset: done");

    // Single key, held until acknowledged
    accept(8'h04, "k04");
    tick(5);
    check("k04_hold_valid", {31'd0, data_valid}, 32'd1);
    check("k04_hold_data", {24'd0, data_out}, 32'h04);
    do_ack("k04");
    key_in = 8'h00;
    tick(8);
    $display("txn press 04: done");

    // Bouncing key never settles long enough
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      key_in = 8'h08;
      for (int j = 0; j < 2; j++) begin tick(1); seen_valid += int'(data_valid); end
      key_in = 8'h00;
      for (int j = 0; j < 2; j++) begin tick(1); seen_valid += int'(data_valid); end
    end
    check("bounce_no_valid", seen_valid, 0);
    accept(8'h08, "k08");
    do_ack("k08");
    key_in = 8'h00;
    tick(8);
    $display("txn bounce 08: done");

    // Chord rejected with a single pulse, then release window enforced
    seen_valid = 0;
    multi_cnt  = 0;
    key_in     = 8'h81;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      multi_cnt  += int'(multi_key);
      seen_valid += int'(data_valid);
    end
    check("chord_multi_pulses", multi_cnt, 1);
    check("chord_no_valid", seen_valid, 0);
    key_in = 8'h00;
    tick(2);
    key_in = 8'h02;
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin tick(1); seen_valid += int'(data_valid); end
    check("early_press_ignored", seen_valid, 0);
    key_in = 8'h00;
    tick(4);
    accept(8'h02, "k02");
    do_ack("k02");
    key_in = 8'h00;
    tick(8);
    $display("txn chord 81 then 02: done");

    // Release during hold keeps valid until ack; minimal release window
    accept(8'h10, "k10");
    key_in   = 8'h00;
    held_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (data_valid === 1'b1 && data_out === 8'h10) held_cnt++;
    end
    check("k10_held_50", held_cnt, 50);
    do_ack("k10");
    tick(2);
    accept(8'h10, "k10_again");
    do_ack("k10_again");
    key_in = 8'h00;
    tick(8);
    $display("txn hold 10: done");

    // Key held through ack is not re-accepted until released
    accept(8'h20, "k20");
    do_ack("k20");
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin tick(1); seen_valid += int'(data_valid); end
    check("k20_no_repeat", seen_valid, 0);
    key_in = 8'h00;
    tick(4);
    accept(8'h20, "k20_again");
    do_ack("k20_again");
    key_in = 8'h00;
    tick(8);
    $display("txn held 20: done");

    // Asynchronous reset during debounce and during hold
    key_in = 8'h01;
    tick(4);
    #2 rst_n = 1'b0;
    #1 check("rst_deb_valid", {31'd0, data_valid}, 32'd0);
    check("rst_deb_multi", {31'd0, multi_key}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    accept(8'h01, "k01_after_rst1");
    tick(3);
    check("k01_in_hold", {31'd0, data_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_hold_valid", {31'd0, data_valid}, 32'd0);
    check("rst_hold_data", {24'd0, data_out}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    accept(8'h01, "k01_after_rst2");
    do_ack("k01");
    key_in = 8'h00;
    tick(8);
    $display("txn reset abort 01: done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_key_onehot_capture

// File: doc/key_onehot_capture.md
KEY_ONEHOT_CAPTURE -- requirements
Module: key_onehot_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized cycles required to accept a press or a release (legal range 2..65535).
REQ-002 SHALL have parameter KEY_W, default 8, number of key lines; the 8-to-3 encoder downstream requires KEY_W = 8.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_in  input  KEY_W  raw key lines, active-high, asynchronous to clk, may bounce.
REQ-006 data_ack  input  1  consumer acknowledge; sampled only while data_valid = 1.
REQ-007 data_out  output  KEY_W  one-hot accepted key pattern, drives the encoder's Data input.
REQ-008 data_valid  output  1  data_out holds a valid one-hot word.
REQ-009 multi_key  output  1  one-cycle pulse: a stable non-one-hot pattern was rejected.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer; key_s is the second flop output, and all other logic uses only key_s.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, HOLD and WAIT_RELEASE.
REQ-012 IDLE: if key_s != 0, SHALL latch cand <= key_s, clear cnt, and go to DEBOUNCE; otherwise remain in IDLE.
REQ-013 DEBOUNCE: if key_s == cand, SHALL increment cnt.
REQ-014 DEBOUNCE: if key_s != cand and key_s == 0, SHALL return to IDLE.
REQ-015 DEBOUNCE: if key_s != cand and key_s != 0, SHALL reload cand <= key_s and clear cnt.
REQ-016 DEBOUNCE with key_s == cand and cnt == DEBOUNCE_CYCLES-1: if cand is one-hot, SHALL register data_out <= cand and data_valid <= 1 and go to HOLD.
REQ-017 DEBOUNCE with key_s == cand and cnt == DEBOUNCE_CYCLES-1: if cand is not one-hot, SHALL pulse multi_key for exactly one cycle and go to WAIT_RELEASE; data_valid stays 0.
REQ-018 Latency: with key_in held stable from rising edge E, data_valid SHALL be high after edge E+2+DEBOUNCE_CYCLES (E = first edge that samples the new value).
REQ-019 HOLD: data_out and data_valid SHALL stay constant, regardless of key_in, until data_ack = 1 is sampled.
REQ-020 HOLD: on the edge sampling data_ack = 1, SHALL clear data_valid, drive data_out <= 0, clear cnt, and go to WAIT_RELEASE.
REQ-021 data_ack while data_valid = 0 SHALL be ignored.
REQ-022 WAIT_RELEASE: SHALL increment cnt while key_s == 0 and clear cnt whenever key_s != 0.
REQ-023 WAIT_RELEASE: reaching cnt == DEBOUNCE_CYCLES-1 with key_s == 0 SHALL return to IDLE; no new press is accepted before then.
REQ-024 data_out SHALL be 0 whenever data_valid = 0, so data_out is never non-one-hot.
REQ-025 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never wrap, because every terminal count forces a state change.
REQ-026 Releasing the key during HOLD SHALL NOT drop data_valid; only data_ack does.

Reset
REQ-027 While rst_n = 0, the block SHALL be in: state IDLE, sync flops 0, cand 0, cnt 0, data_out 0, data_valid 0, multi_key 0.
REQ-028 Reset asserted mid-operation (any state) SHALL abort immediately with no output pulse; after release, a still-pressed key SHALL be re-debounced from IDLE.

Structure
REQ-029 Shared package key_capture_pkg SHALL hold the state enum type, KEY_W_DEF = 8 and DEBOUNCE_DEF = 16.
REQ-030 The synchronizer SHALL be the sub-module sync_2ff (parameter WIDTH, ports clk, rst_n, d, q), reset to 0.
REQ-031 The one-hot check SHALL be (cand != 0) && ((cand & (cand-1)) == 0).
REQ-032 All outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 key_in 8'h04 held from edge 10 -> data_valid = 1 and data_out = 8'h04 after edge 16; both held until data_ack.
REQ-034 key_in toggles 8'h08/8'h00 every 2 cycles for 20 cycles, then holds 8'h08 -> no data_valid during bouncing; data_valid asserts 6 edges after the final stable value.
REQ-035 key_in 8'h81 held 10 cycles -> exactly one multi_key pulse, data_valid stays 0; a later 8'h02 press is accepted only after 4 released cycles.
REQ-036 Valid 8'h10 in HOLD; key released and data_ack held 0 for 50 cycles -> data_valid stays 1; data_ack = 1 for 1 cycle -> data_valid = 0 and data_out = 0 next cycle; return to IDLE after 4 released cycles.
REQ-037 Key 8'h20 held through ack -> no second data_valid until key_in = 0 for 4 cycles and 8'h20 is pressed again.
REQ-038 rst_n pulsed low during DEBOUNCE and again during HOLD -> outputs 0 asynchronously; held key 8'h01 re-accepted 2+DEBOUNCE_CYCLES+1 edges after reset release.
